// File: rtl/time_set_ctrl.sv
// time_set_ctrl: set-button front end for clock/alarm time editing.
// Synchronises and debounces the raw set key, then turns press / hold /
// auto-repeat into single-step edits of the hour or minute field.
// A rising edge of en preloads the current time so editing starts from it.
// Optional build macro TIME_SET_DEC_EN adds a key_dec button that steps the
// selected field downward; pressing both keys together does nothing.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | waiting for a fresh debounced press (rising edge of kdb)
// PRESS  | key held after the first step, counting towards auto-repeat
// REPEAT | auto-repeat running, one step every REP_CYCLES
module time_set_ctrl #(
    parameter int unsigned DEB_CYCLES  = 1000000,
    parameter int unsigned HOLD_CYCLES = 25000000,
    parameter int unsigned REP_CYCLES  = 5000000,
    parameter int unsigned CNT_W       = 25
) (
    input  logic       clk,
    input  logic       clrn,
    input  logic       en,
    input  logic       h_m,
    input  logic       key_raw,
`ifdef TIME_SET_DEC_EN
    input  logic       key_dec,
`endif
    input  logic [7:0] cur_hour,
    input  logic [7:0] cur_min,
    input  logic [7:0] cur_sec,
    output logic [7:0] hour,
    output logic [7:0] min,
    output logic [7:0] sec,
    output logic       upd
);

`ifdef TIME_SET_DEC_EN
    localparam int NK = 2;
`else
    localparam int NK = 1;
`endif

    localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEB_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REP_CYCLES - 1);
    localparam logic [7:0]       HOUR_MAX  = 8'd23;
    localparam logic [7:0]       MIN_MAX   = 8'd59;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PRESS  = 2'd1,
        REPEAT = 2'd2
    } state_t;

    // Key 0 is the increment key; key 1 (when built) is the decrement key.
    logic [NK-1:0]    keys;
    logic [NK-1:0]    sync1;
    logic [NK-1:0]    ks;
    logic [NK-1:0]    kdb;
    logic [NK-1:0]    kdb_q;
    logic [CNT_W-1:0] deb_cnt [NK];

    state_t           state;
    logic             en_q;
    logic             dir;
    logic [CNT_W-1:0] hold_cnt;
    logic [CNT_W-1:0] rep_cnt;

    logic inc_lvl, inc_rise, dec_lvl, dec_rise;
    logic both, held_lvl, sel_dir;
    logic [7:0] nxt_hour, nxt_min, nxt_sec;

`ifdef TIME_SET_DEC_EN
    assign keys     = {key_dec, key_raw};
    assign dec_lvl  = kdb[1];
    assign dec_rise = kdb[1] & ~kdb_q[1];
`else
    assign keys     = key_raw;
    assign dec_lvl  = 1'b0;
    assign dec_rise = 1'b0;
`endif

    assign inc_lvl  = kdb[0];
    assign inc_rise = kdb[0] & ~kdb_q[0];
    assign both     = inc_lvl & dec_lvl;
    assign held_lvl = dir ? dec_lvl : inc_lvl;
    // In IDLE the direction comes from whichever key just rose; afterwards it is latched.
    assign sel_dir  = (state == IDLE) ? dec_rise : dir;

    function automatic logic [7:0] step_up(input logic [7:0] v, input logic [7:0] vmax);
        return (v >= vmax) ? 8'd0 : v + 8'd1;
    endfunction

    function automatic logic [7:0] step_dn(input logic [7:0] v, input logic [7:0] vmax);
        return (v == 8'd0 || v > vmax) ? vmax : v - 8'd1;
    endfunction

    // Two-flop synchroniser and per-key debounce: a level is accepted after DEB_CYCLES stable samples.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            sync1 <= '0;
            ks    <= '0;
            kdb   <= '0;
            kdb_q <= '0;
            for (int i = 0; i < NK; i++) deb_cnt[i] <= '0;
        end else begin
            sync1 <= keys;
            ks    <= sync1;
            kdb_q <= kdb;
            for (int i = 0; i < NK; i++) begin
                if (ks[i] == kdb[i]) begin
                    deb_cnt[i] <= '0;
                end else if (deb_cnt[i] == DEB_LAST) begin
                    kdb[i]     <= ks[i];
                    deb_cnt[i] <= '0;
                end else begin
                    deb_cnt[i] <= deb_cnt[i] + 1'b1;
                end
            end
        end
    end

    // Candidate values for one step of the currently selected field; minute steps clear seconds.
    always_comb begin
        nxt_hour = hour;
        nxt_min  = min;
        nxt_sec  = sec;
        if (h_m) begin
            nxt_hour = sel_dir ? step_dn(hour, HOUR_MAX) : step_up(hour, HOUR_MAX);
        end else begin
            nxt_min = sel_dir ? step_dn(min, MIN_MAX) : step_up(min, MIN_MAX);
            nxt_sec = 8'd0;
        end
    end

    // Press/hold/repeat sequencer with registered time outputs; preload on en rising wins over stepping.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state    <= IDLE;
            en_q     <= 1'b0;
            dir      <= 1'b0;
            hold_cnt <= '0;
            rep_cnt  <= '0;
            hour     <= 8'd0;
            min      <= 8'd0;
            sec      <= 8'd0;
            upd      <= 1'b0;
        end else begin
            en_q <= en;
            upd  <= 1'b0;
            if (en && !en_q) begin
                hour     <= cur_hour;
                min      <= cur_min;
                sec      <= cur_sec;
                upd      <= 1'b1;
                state    <= IDLE;
                hold_cnt <= '0;
                rep_cnt  <= '0;
            end else if (!en) begin
                state    <= IDLE;
                hold_cnt <= '0;
                rep_cnt  <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (!both && (inc_rise || dec_rise)) begin
                            hour     <= nxt_hour;
                            min      <= nxt_min;
                            sec      <= nxt_sec;
                            upd      <= 1'b1;
                            dir      <= dec_rise;
                            hold_cnt <= '0;
                            state    <= PRESS;
                        end
                    end
                    PRESS: begin
                        if (both || !held_lvl) begin
                            hold_cnt <= '0;
                            state    <= IDLE;
                        end else if (hold_cnt == HOLD_LAST) begin
                            hour     <= nxt_hour;
                            min      <= nxt_min;
                            sec      <= nxt_sec;
                            upd      <= 1'b1;
                            hold_cnt <= '0;
                            rep_cnt  <= '0;
                            state    <= REPEAT;
                        end else begin
                            hold_cnt <= hold_cnt + 1'b1;
                        end
                    end
                    REPEAT: begin
                        if (both || !held_lvl) begin
                            rep_cnt <= '0;
                            state   <= IDLE;
                        end else if (rep_cnt == REP_LAST) begin
                            hour    <= nxt_hour;
                            min     <= nxt_min;
                            sec     <= nxt_sec;
                            upd     <= 1'b1;
                            rep_cnt <= '0;
                        end else begin
                            rep_cnt <= rep_cnt + 1'b1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: doc/time_set_ctrl.md
Name: time_set_ctrl

Overview:
- Upstream stage of the clock/alarm time-setting path.
- Turns the raw set push-button into clean increments of hour or minute. Includes synchroniser, debounce, and auto-repeat on hold.
- Outputs binary hour/min/sec registers consumed by the clock core (set/load path) and by the alarm-time store.
- One instance per target: clock-set and alarm-set.

Parameters:
- DEB_CYCLES, 1000000: consecutive stable synchronised samples needed to accept a key level change (20 ms at 50 MHz).
- HOLD_CYCLES, 25000000: cycles a debounced press must last before auto-repeat starts.
- REP_CYCLES, 5000000: cycles between auto-repeat increments.
- CNT_W, 25: width of the debounce, hold and repeat counters; must hold the largest of the three parameters.

Ports:
- clk  in  1  system clock, 50 MHz.
- clrn  in  1  asynchronous active-low reset.
- en  in  1  setting mode active (set && target-select from switches).
- h_m  in  1  field select: 1 = hour, 0 = minute.
- key_raw  in  1  raw set button, active-high, bouncing, asynchronous.
- cur_hour  in  8  current value to preload, 0..23.
- cur_min  in  8  current value to preload, 0..59.
- cur_sec  in  8  current value to preload, 0..59.
- hour  out  8  edited hour, binary 0..23.
- min  out  8  edited minute, binary 0..59.
- sec  out  8  edited second, binary 0..59.
- upd  out  1  one-cycle pulse on every value change, including preload.

Behaviour:
- Reset (clrn=0, async): hour=min=sec=0, upd=0, FSM=IDLE, all counters 0, synchroniser and debounced level 0, en_q=0.
- Synchroniser: 2 flip-flops on key_raw, giving ks.
- Debounce:
  - Counter increments while ks != kdb and clears when ks == kdb.
  - When the counter reaches DEB_CYCLES-1, kdb <= ks and the counter clears.
  - Any bounce restarts the count.
- Preload: en rising edge (en=1, en_q=0) loads cur_* into hour/min/sec, pulses upd and forces IDLE. Preload wins over any increment in the same cycle.
- Increment, on the field selected by h_m in that cycle:
  - Hour: 23 wraps to 0.
  - Minute: 59 wraps to 0, and sec is cleared to 0.
  - Hour increments leave min and sec unchanged.
  - Every increment registers the new value and pulses upd for exactly 1 cycle.
- FSM (active only while en=1):
  - IDLE: kdb rising edge -> increment, go to PRESS, clear hold counter.
  - PRESS: kdb=1 -> hold counter counts; on reaching HOLD_CYCLES-1 -> increment, go to REPEAT, clear repeat counter. kdb=0 -> IDLE.
  - REPEAT: kdb=1 -> repeat counter counts; on reaching REP_CYCLES-1 -> increment, clear counter, stay in REPEAT. kdb=0 -> IDLE.
  - h_m change while held: no extra increment; subsequent increments go to the newly selected field.
- en=0: FSM forced to IDLE, hold/repeat counters cleared, outputs keep their values, no increments. Debounce keeps running.
- Key already held when en rises: no increment until kdb falls and rises again.
- Latency: key stable from cycle t -> kdb=1 at t+2+DEB_CYCLES -> new value on outputs and upd=1 one cycle later.
- Out-of-range cur_* (hour>23 or min/sec>59) is loaded as-is. The next increment of that field wraps it to 0.

Optional Feature:
- Macro: TIME_SET_DEC_EN.
- Defined:
  - Adds input key_dec (1 bit, raw, active-high) with its own synchroniser and debounce.
  - Its press/hold/repeat decrements the selected field: hour 0 -> 23, minute 0 -> 59 with sec cleared.
  - If both keys are debounced-pressed, neither acts and the FSM stays in or returns to IDLE until both are released.
- Undefined: no key_dec port; increment only.

Test Plan:
- Reset: clrn=0 mid-REPEAT -> hour=min=sec=0, upd=0 immediately; after release, no increment until a fresh press. Bench uses DEB_CYCLES=4, HOLD_CYCLES=20, REP_CYCLES=5.
- Preload and single press: en rises with cur=12:34:56 -> outputs 12:34:56 with one upd pulse. h_m=0, key held 10 cycles -> min=35, sec=0, exactly one upd.
- Bounce: key toggles every 2 cycles for 12 cycles then settles high -> exactly one increment, landing 2+4+1 cycles after settling.
- Wrap: hour=23, h_m=1, press -> hour=0, min and sec unchanged. min=59, h_m=0, press -> min=0, hour unchanged.
- Auto-repeat: min=00, h_m=0, key held 60 cycles -> increments at press, +20, then every 5 cycles; after release the count of upd pulses equals the minute value.
- en drop mid-hold: en=0 during REPEAT -> no further increments, values held. Re-raising en preloads cur_*, and no increment occurs while the key is still held.
